// File: rtl/div_unit_if.sv
// Request/response bundle for the multi-cycle divide/remainder unit.
// Signal names mirror the unit's port list; the slave side is the divider.
interface div_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [1:0]      div_op_i;
    logic [XLEN-1:0] data_1_i;
    logic [XLEN-1:0] data_2_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [XLEN-1:0] alu_result_o;
    logic            zero_o;

    modport master (
        output req_valid_i,
        output div_op_i,
        output data_1_i,
        output data_2_i,
        output res_ready_i,
        input  req_ready_o,
        input  res_valid_o,
        input  alu_result_o,
        input  zero_o
    );

    modport slave (
        input  req_valid_i,
        input  div_op_i,
        input  data_1_i,
        input  data_2_i,
        input  res_ready_i,
        output req_ready_o,
        output res_valid_o,
        output alu_result_o,
        output zero_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle RISC-V M-extension divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per cycle, with valid/ready
// handshakes on both the request and result sides.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    div_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;       // extra bit holds the trial-subtract borrow
    logic [XLEN-1:0] quot_q, quot_d;     // dividend shifts out as quotient shifts in
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            rem_sel_q, rem_sel_d; // 1: return remainder, 0: quotient
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quot;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic            signed_op;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;

    // One restoring step plus sign correction of its outcome.
    always_comb begin
        shifted = {rem_q, quot_q[XLEN-1]};
        diff    = shifted - {2'b00, divisor_q};
        if (!diff[XLEN+1]) begin
            step_rem  = diff[XLEN:0];
            step_quot = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            step_rem  = shifted[XLEN:0];
            step_quot = {quot_q[XLEN-2:0], 1'b0};
        end
        q_fix = q_neg_q ? (~step_quot + 1'b1) : step_quot;
        r_fix = r_neg_q ? (~step_rem[XLEN-1:0] + 1'b1) : step_rem[XLEN-1:0];
    end

    // Operand magnitudes for signed ops; unsigned ops pass straight through.
    always_comb begin
        signed_op = ~bus.div_op_i[0];
        a_abs     = bus.data_1_i;
        b_abs     = bus.data_2_i;
        if (signed_op && bus.data_1_i[XLEN-1]) begin
            a_abs = ~bus.data_1_i + 1'b1;
        end
        if (signed_op && bus.data_2_i[XLEN-1]) begin
            b_abs = ~bus.data_2_i + 1'b1;
        end
    end

    // Next-state logic: accept, iterate, hold result until consumed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        rem_sel_d = rem_sel_q;
        result_d  = result_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid_i) begin
                    rem_sel_d = bus.div_op_i[1];
                    if (bus.data_2_i == '0) begin
                        // Divide by zero: all-ones quotient, raw dividend as remainder.
                        result_d = bus.div_op_i[1] ? bus.data_1_i : '1;
                        state_d  = StDone;
                    end else if (signed_op && (bus.data_1_i == IntMin) &&
                                 (bus.data_2_i == '1)) begin
                        // Signed overflow: quotient wraps to INT_MIN, remainder 0.
                        result_d = bus.div_op_i[1] ? '0 : IntMin;
                        state_d  = StDone;
                    end else begin
                        rem_d     = '0;
                        quot_d    = a_abs;
                        divisor_d = b_abs;
                        q_neg_d   = signed_op & (bus.data_1_i[XLEN-1] ^ bus.data_2_i[XLEN-1]);
                        r_neg_d   = signed_op & bus.data_1_i[XLEN-1];
                        cnt_d     = '0;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    result_d = rem_sel_q ? r_fix : q_fix;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            rem_sel_q <= rem_sel_d;
            result_q  <= result_d;
        end
    end

    assign bus.req_ready_o  = (state_q == StIdle);
    assign bus.res_valid_o  = (state_q == StDone);
    assign bus.alu_result_o = result_q;
    assign bus.zero_o       = (result_q == '0);
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected results and latencies are queued
// when a request is driven and compared when the unit presents its result.
module tb_div_unit;
    logic clk;
    logic rst;

    div_unit_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    int          edge_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0) begin
            r = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = op[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            case (op)
                2'd0:    r = $signed(a) / $signed(b);
                2'd1:    r = a / b;
                2'd2:    r = $signed(a) % $signed(b);
                default: r = a % b;
            endcase
        end
        return r;
    endfunction

    function automatic int ref_edges(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Issue one request; the number of edges after the accept edge before
    // res_valid_o is seen (0 for fast path, 32 for normal) is checked too.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_edges,
                          input bit hold, input bit mangle);
        int          n;
        bit          got;
        logic [31:0] e;
        int          ee;
        logic [31:0] held;
        @(negedge clk);
        check({tag, "_reqrdy"}, {31'd0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i = 1'b1;
        bus.div_op_i    = op;
        bus.data_1_i    = a;
        bus.data_2_i    = b;
        bus.res_ready_i = !hold;
        exp_q.push_back(exp);
        edge_q.push_back(exp_edges);
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            if (n == 0 && !hold) bus.req_valid_i = 1'b0;
            if (mangle && n == 5) begin
                bus.data_1_i = ~bus.data_1_i;
                bus.data_2_i = bus.data_2_i + 32'd1;
            end
            if (bus.res_valid_o) got = 1'b1;
            else n++;
        end
        e  = exp_q.pop_front();
        ee = edge_q.pop_front();
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            bus.req_valid_i = 1'b0;
            bus.res_ready_i = 1'b1;
            return;
        end
        check({tag, "_lat"}, n, ee);
        check({tag, "_res"}, bus.alu_result_o, e);
        check({tag, "_zero"}, {31'd0, bus.zero_o}, {31'd0, (e == 32'd0)});
        if (hold) begin
            held = bus.alu_result_o;
            repeat (10) begin
                @(negedge clk);
                check({tag, "_hvalid"}, {31'd0, bus.res_valid_o}, 32'd1);
                check({tag, "_hres"}, bus.alu_result_o, held);
                check({tag, "_hreqrdy"}, {31'd0, bus.req_ready_o}, 32'd0);
            end
            bus.res_ready_i = 1'b1;
            bus.req_valid_i = 1'b0;
        end
        @(negedge clk);
        check({tag, "_vdrop"}, {31'd0, bus.res_valid_o}, 32'd0);
        check({tag, "_idle"}, {31'd0, bus.req_ready_o}, 32'd1);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          seen;
        rst             = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.div_op_i    = 2'd0;
        bus.data_1_i    = 32'd0;
        bus.data_2_i    = 32'd0;
        bus.res_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_reqrdy", {31'd0, bus.req_ready_o}, 32'd1);
        check("rst_valid", {31'd0, bus.res_valid_o}, 32'd0);
        check("rst_result", bus.alu_result_o, 32'd0);
        check("rst_zero", {31'd0, bus.zero_o}, 32'd1);
        rst = 1'b0;

        run_op("divu", 2'd1, 32'd100, 32'd7, 32'd14, 32, 1'b0, 1'b0);
        run_op("remu", 2'd3, 32'd100, 32'd7, 32'd2, 32, 1'b0, 1'b0);
        run_op("div_nm7_2", 2'd0, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32, 1'b0, 1'b0);
        run_op("rem_nm7_2", 2'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32, 1'b0, 1'b0);
        run_op("div_7_n2", 2'd0, 32'd7, -32'sd2, 32'hFFFF_FFFD, 32, 1'b0, 1'b0);
        run_op("rem_7_n2", 2'd2, 32'd7, -32'sd2, 32'd1, 32, 1'b0, 1'b0);
        run_op("div_n7_n2", 2'd0, -32'sd7, -32'sd2, 32'd3, 32, 1'b0, 1'b0);
        run_op("rem_n7_n2", 2'd2, -32'sd7, -32'sd2, 32'hFFFF_FFFF, 32, 1'b0, 1'b0);
        run_op("div_by0", 2'd0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        run_op("remu_by0", 2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 0, 1'b0, 1'b0);
        run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0, 1'b0);
        run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0, 1'b0);
        run_op("bp_divu", 2'd1, 32'd1000, 32'd10, 32'd100, 32, 1'b1, 1'b0);
        run_op("mangle", 2'd1, 32'd100, 32'd7, 32'd14, 32, 1'b0, 1'b1);

        // Reset asserted across iteration 15 of a long divide.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.div_op_i    = 2'd1;
        bus.data_1_i    = 32'hFFFF_FFFF;
        bus.data_2_i    = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_reqrdy", {31'd0, bus.req_ready_o}, 32'd1);
        check("midrst_valid", {31'd0, bus.res_valid_o}, 32'd0);
        check("midrst_result", bus.alu_result_o, 32'd0);
        check("midrst_zero", {31'd0, bus.zero_o}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.res_valid_o) seen = 1'b1;
        end
        check("midrst_novalid", {31'd0, seen}, 32'd0);
        run_op("post_rst", 2'd1, 32'd9, 32'd3, 32'd3, 32, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i % 4 == 1) b = -b;
            run_op($sformatf("rnd%0d", i), op, a, b, ref_div(op, a, b), ref_edges(op, a, b),
                   1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
